// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencer for C = A x B over NxN memories, one MAC per cycle.
// Define MATMUL_SAT_EN to saturate c_writeData instead of truncating it.
module matmul_ctrl #(
    parameter int N          = 10,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
    parameter int OUT_WIDTH  = ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  a_en_ReadMat,
    output logic [ADDR_WIDTH-1:0] a_rowAddr,
    output logic [ADDR_WIDTH-1:0] a_colAddr,
    input  logic [DATA_WIDTH-1:0] a_readData,
    output logic                  b_en_ReadMat,
    output logic [ADDR_WIDTH-1:0] b_rowAddr,
    output logic [ADDR_WIDTH-1:0] b_colAddr,
    input  logic [DATA_WIDTH-1:0] b_readData,
    output logic                  c_en_WriteMat,
    output logic [ADDR_WIDTH-1:0] c_rowAddr,
    output logic [ADDR_WIDTH-1:0] c_colAddr,
    output logic [OUT_WIDTH-1:0]  c_writeData
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N-1);
    localparam bit SINGLE = (N == 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] i, j, k;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  prod;
    logic [OUT_WIDTH-1:0]  c_val;

    assign prod = ACC_WIDTH'(a_readData) * ACC_WIDTH'(b_readData);

    // Read data lags the address by one cycle, so READ k=1 sees the k=0 product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                    if (start)
                        state <= S_READ;
                end
                S_READ: begin
                    if (k == ADDR_WIDTH'(1))
                        acc <= prod;
                    else if (k != '0)
                        acc <= acc + prod;
                    if (k == LAST_IDX) begin
                        k     <= '0;
                        state <= S_LAST;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_LAST: begin
                    acc   <= SINGLE ? prod : acc + prod;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    state <= S_READ;
                    if (j == LAST_IDX) begin
                        j <= '0;
                        if (i == LAST_IDX) begin
                            i     <= '0;
                            state <= S_DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MATMUL_SAT_EN
    localparam logic [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'({OUT_WIDTH{1'b1}});
    assign c_val = (acc > OUT_MAX) ? OUT_MAX[OUT_WIDTH-1:0]
                                   : acc[OUT_WIDTH-1:0];
`else
    assign c_val = acc[OUT_WIDTH-1:0];
`endif

    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        a_en_ReadMat  = 1'b0;
        b_en_ReadMat  = 1'b0;
        c_en_WriteMat = 1'b0;
        a_rowAddr     = '0;
        a_colAddr     = '0;
        b_rowAddr     = '0;
        b_colAddr     = '0;
        c_rowAddr     = '0;
        c_colAddr     = '0;
        c_writeData   = '0;
        if (state == S_READ) begin
            a_en_ReadMat = 1'b1;
            b_en_ReadMat = 1'b1;
            a_rowAddr    = i;
            a_colAddr    = k;
            b_rowAddr    = k;
            b_colAddr    = j;
        end
        if (state == S_WRITE) begin
            c_en_WriteMat = 1'b1;
            c_rowAddr     = i;
            c_colAddr     = j;
            c_writeData   = c_val;
        end
    end

endmodule
